// File: rtl/wav_dfi_lp_req_seq.sv
// DFI low-power request sequencer: two identical channel FSMs (ctrl, data) driving lp req/wakeup.
// Optional statistics counters are enabled with `define WAV_DFI_LP_STATS_EN.
module wav_dfi_lp_req_seq_ch #(
  parameter int RESP_W = 8,
  parameter int WAKE_W = 16,
  parameter int STAT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [RESP_W-1:0] cfg_lp_resp,
  input  logic [WAKE_W-1:0] cfg_wake_tmo,
  input  logic [5:0]        cfg_wakeup,
  input  logic              want,
  input  logic              ack,
  output logic              req,
  output logic [5:0]        wakeup,
  output logic [1:0]        state,
  output logic              denied,
`ifdef WAV_DFI_LP_STATS_EN
  output logic [STAT_W-1:0] entries,
  output logic [STAT_W-1:0] denies,
  output logic [STAT_W-1:0] errs,
`endif
  output logic              err
);
  localparam int CNT_W = (RESP_W > WAKE_W) ? RESP_W : WAKE_W;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, LP = 2'd2, EXIT = 2'd3} state_t;

  state_t             st, st_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [5:0]         wake_nxt;
  logic               rearm, rearm_nxt, fired, fired_nxt;
  logic               deny_nxt, err_nxt, entry, req_nxt;
  logic [RESP_W-1:0]  resp_last;

  // A zero response window behaves like a single-cycle window.
  assign resp_last = ((cfg_lp_resp == '0) ? RESP_W'(1) : cfg_lp_resp) - RESP_W'(1);
  assign state     = st;
  assign req_nxt   = (st_nxt == REQ) || (st_nxt == LP);

  always_comb begin
    st_nxt    = st;
    cnt_nxt   = cnt;
    fired_nxt = fired;
    wake_nxt  = wakeup;
    deny_nxt  = 1'b0;
    err_nxt   = 1'b0;
    entry     = 1'b0;
    rearm_nxt = want ? rearm : 1'b1;
    case (st)
      IDLE: if (want && rearm) begin
        st_nxt   = REQ;
        cnt_nxt  = '0;
        wake_nxt = cfg_wakeup;
      end
      REQ: if (ack) begin
        st_nxt = LP;
        entry  = 1'b1;
      end else if (!want) begin
        st_nxt    = EXIT;
        cnt_nxt   = '0;
        fired_nxt = 1'b0;
      end else if (cnt == CNT_W'(resp_last)) begin
        st_nxt    = IDLE;
        deny_nxt  = 1'b1;
        rearm_nxt = 1'b0;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
      LP: if (!want || !ack) begin
        // ack vanishing while we still request is a PHY protocol violation
        st_nxt    = EXIT;
        cnt_nxt   = '0;
        fired_nxt = 1'b0;
        err_nxt   = want;
      end
      EXIT: if (!ack) begin
        st_nxt = IDLE;
      end else begin
        cnt_nxt = (&cnt) ? cnt : cnt + CNT_W'(1);
        if (!fired && cnt_nxt >= CNT_W'(cfg_wake_tmo)) begin
          err_nxt   = 1'b1;
          fired_nxt = 1'b1;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st     <= IDLE;
      cnt    <= '0;
      req    <= 1'b0;
      wakeup <= '0;
      denied <= 1'b0;
      err    <= 1'b0;
      rearm  <= 1'b1;
      fired  <= 1'b0;
    end else begin
      st     <= st_nxt;
      cnt    <= cnt_nxt;
      req    <= req_nxt;
      wakeup <= wake_nxt;
      denied <= deny_nxt;
      err    <= err_nxt;
      rearm  <= rearm_nxt;
      fired  <= fired_nxt;
    end
  end

`ifdef WAV_DFI_LP_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entries <= '0;
      denies  <= '0;
      errs    <= '0;
    end else begin
      if (entry && !(&entries))   entries <= entries + STAT_W'(1);
      if (deny_nxt && !(&denies)) denies  <= denies + STAT_W'(1);
      if (err_nxt && !(&errs))    errs    <= errs + STAT_W'(1);
    end
  end
`endif
endmodule

module wav_dfi_lp_req_seq #(
  parameter int RESP_W = 8,
  parameter int WAKE_W = 16,
  parameter int STAT_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [RESP_W-1:0] cfg_lp_resp,
  input  logic [WAKE_W-1:0] cfg_wake_tmo,
  input  logic [5:0]        cfg_ctrl_wakeup,
  input  logic [5:0]        cfg_data_wakeup,
  input  logic              ctrl_lp_want,
  input  logic              data_lp_want,
  input  logic              lp_ctrl_ack,
  input  logic              lp_data_ack,
  output logic              lp_ctrl_req,
  output logic [5:0]        lp_ctrl_wakeup,
  output logic              lp_data_req,
  output logic [5:0]        lp_data_wakeup,
  output logic [1:0]        ctrl_state,
  output logic [1:0]        data_state,
  output logic              ctrl_denied,
  output logic              data_denied,
`ifdef WAV_DFI_LP_STATS_EN
  output logic [STAT_W-1:0] ctrl_entries,
  output logic [STAT_W-1:0] data_entries,
  output logic [STAT_W-1:0] ctrl_denies,
  output logic [STAT_W-1:0] data_denies,
  output logic [STAT_W-1:0] ctrl_errs,
  output logic [STAT_W-1:0] data_errs,
`endif
  output logic              ctrl_err,
  output logic              data_err
);
  wav_dfi_lp_req_seq_ch #(.RESP_W(RESP_W), .WAKE_W(WAKE_W), .STAT_W(STAT_W)) u_ctrl (
    .clock(clock), .reset(reset), .cfg_lp_resp(cfg_lp_resp), .cfg_wake_tmo(cfg_wake_tmo),
    .cfg_wakeup(cfg_ctrl_wakeup), .want(ctrl_lp_want), .ack(lp_ctrl_ack),
    .req(lp_ctrl_req), .wakeup(lp_ctrl_wakeup), .state(ctrl_state), .denied(ctrl_denied),
`ifdef WAV_DFI_LP_STATS_EN
    .entries(ctrl_entries), .denies(ctrl_denies), .errs(ctrl_errs),
`endif
    .err(ctrl_err)
  );

  wav_dfi_lp_req_seq_ch #(.RESP_W(RESP_W), .WAKE_W(WAKE_W), .STAT_W(STAT_W)) u_data (
    .clock(clock), .reset(reset), .cfg_lp_resp(cfg_lp_resp), .cfg_wake_tmo(cfg_wake_tmo),
    .cfg_wakeup(cfg_data_wakeup), .want(data_lp_want), .ack(lp_data_ack),
    .req(lp_data_req), .wakeup(lp_data_wakeup), .state(data_state), .denied(data_denied),
`ifdef WAV_DFI_LP_STATS_EN
    .entries(data_entries), .denies(data_denies), .errs(data_errs),
`endif
    .err(data_err)
  );
endmodule

// File: tb/tb_wav_dfi_lp_req_seq.sv
// Directed bench for wav_dfi_lp_req_seq: handshake, deny, wake timeout, protocol error, wakeup latch, reset.
module tb_wav_dfi_lp_req_seq;
  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  cfg_lp_resp;
  logic [15:0] cfg_wake_tmo;
  logic [5:0]  cfg_ctrl_wakeup, cfg_data_wakeup;
  logic        ctrl_lp_want, data_lp_want, lp_ctrl_ack, lp_data_ack;
  logic        lp_ctrl_req, lp_data_req;
  logic [5:0]  lp_ctrl_wakeup, lp_data_wakeup;
  logic [1:0]  ctrl_state, data_state;
  logic        ctrl_denied, data_denied, ctrl_err, data_err;
`ifdef WAV_DFI_LP_STATS_EN
  logic [15:0] ctrl_entries, data_entries, ctrl_denies, data_denies, ctrl_errs, data_errs;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  wav_dfi_lp_req_seq dut (
    .clock(clock), .reset(reset), .cfg_lp_resp(cfg_lp_resp), .cfg_wake_tmo(cfg_wake_tmo),
    .cfg_ctrl_wakeup(cfg_ctrl_wakeup), .cfg_data_wakeup(cfg_data_wakeup),
    .ctrl_lp_want(ctrl_lp_want), .data_lp_want(data_lp_want),
    .lp_ctrl_ack(lp_ctrl_ack), .lp_data_ack(lp_data_ack),
    .lp_ctrl_req(lp_ctrl_req), .lp_ctrl_wakeup(lp_ctrl_wakeup),
    .lp_data_req(lp_data_req), .lp_data_wakeup(lp_data_wakeup),
    .ctrl_state(ctrl_state), .data_state(data_state),
    .ctrl_denied(ctrl_denied), .data_denied(data_denied),
`ifdef WAV_DFI_LP_STATS_EN
    .ctrl_entries(ctrl_entries), .data_entries(data_entries),
    .ctrl_denies(ctrl_denies), .data_denies(data_denies),
    .ctrl_errs(ctrl_errs), .data_errs(data_errs),
`endif
    .ctrl_err(ctrl_err), .data_err(data_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // inputs change 1 time unit after the rising edge; outputs are read at that same point
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    cfg_lp_resp = 8'd4; cfg_wake_tmo = 16'd10;
    cfg_ctrl_wakeup = 6'd5; cfg_data_wakeup = 6'd3;
    ctrl_lp_want = 0; data_lp_want = 0; lp_ctrl_ack = 0; lp_data_ack = 0;
    tick(2);
    check("rst_ctrl_state", ctrl_state, 0);
    check("rst_ctrl_req", lp_ctrl_req, 0);
    check("rst_ctrl_wakeup", lp_ctrl_wakeup, 0);
    check("rst_data_req", lp_data_req, 0);
    check("rst_pulses", {ctrl_denied, data_denied, ctrl_err, data_err}, 0);
    reset = 1'b0;
    tick();

    // T1 + T5: normal entry with wakeup 5, config changes during LP
    ctrl_lp_want = 1;
    tick();
    check("t1_req_rise", lp_ctrl_req, 1);
    check("t1_state_req", ctrl_state, 1);
    check("t1_wakeup", lp_ctrl_wakeup, 5);
    tick();
    lp_ctrl_ack = 1;
    tick();
    check("t1_state_lp", ctrl_state, 2);
    check("t1_no_deny", ctrl_denied, 0);
    cfg_ctrl_wakeup = 6'd9;
    tick(3);
    check("t5_wakeup_held", lp_ctrl_wakeup, 5);
    check("t1_req_in_lp", lp_ctrl_req, 1);
    ctrl_lp_want = 0;
    tick();
    check("t1_req_fall", lp_ctrl_req, 0);
    check("t1_state_exit", ctrl_state, 3);
    lp_ctrl_ack = 0;
    tick();
    check("t1_state_idle", ctrl_state, 0);
    check("t5_wakeup_retain", lp_ctrl_wakeup, 5);
    ctrl_lp_want = 1;
    tick();
    check("t5_wakeup_new", lp_ctrl_wakeup, 9);
    lp_ctrl_ack = 1;
    tick();
    check("t5_state_lp", ctrl_state, 2);
    ctrl_lp_want = 0;
    tick();
    lp_ctrl_ack = 0;
    tick();
    check("t5_idle", ctrl_state, 0);

    // T2: data channel denied after 4 cycles, no retry until want toggles
    data_lp_want = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t2_req_high", lp_data_req, 1);
      check("t2_no_deny_yet", data_denied, 0);
    end
    tick();
    check("t2_req_drop", lp_data_req, 0);
    check("t2_denied", data_denied, 1);
    check("t2_state_idle", data_state, 0);
    tick();
    check("t2_deny_pulse", data_denied, 0);
    tick(3);
    check("t2_no_retry", lp_data_req, 0);
    data_lp_want = 0;
    tick();
    data_lp_want = 1;
    tick();
    check("t2_rearm_req", lp_data_req, 1);
    data_lp_want = 0;
    tick();
    check("t2_exit", data_state, 3);
    tick();
    check("t2_idle", data_state, 0);

    // T3: wake timeout of 10 with ack held 15 cycles after req fall
    ctrl_lp_want = 1;
    tick();
    lp_ctrl_ack = 1;
    tick();
    ctrl_lp_want = 0;
    tick();
    check("t3_req_fall", lp_ctrl_req, 0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("t3_err_c%0d", k), ctrl_err, (k == 10) ? 1 : 0);
    end
    check("t3_still_exit", ctrl_state, 3);
    lp_ctrl_ack = 0;
    tick();
    check("t3_idle", ctrl_state, 0);

    // T4: PHY drops ack while data channel is in LP
    data_lp_want = 1;
    tick();
    lp_data_ack = 1;
    tick();
    check("t4_state_lp", data_state, 2);
    lp_data_ack = 0;
    tick();
    check("t4_err", data_err, 1);
    check("t4_req_drop", lp_data_req, 0);
    check("t4_exit", data_state, 3);
    data_lp_want = 0;
    tick();
    check("t4_err_pulse", data_err, 0);
    check("t4_idle", data_state, 0);

    // T6: concurrent channels, then async reset during REQ and during EXIT
    cfg_ctrl_wakeup = 6'd21; cfg_data_wakeup = 6'd42;
    ctrl_lp_want = 1; data_lp_want = 1;
    tick();
    check("t6_ctrl_wake", lp_ctrl_wakeup, 21);
    check("t6_data_wake", lp_data_wakeup, 42);
    lp_data_ack = 1;
    tick();
    check("t6_ctrl_req_st", ctrl_state, 1);
    check("t6_data_lp_st", data_state, 2);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_req", {lp_ctrl_req, lp_data_req}, 0);
    check("t6_rst_state", {ctrl_state, data_state}, 0);
    check("t6_rst_wake", {lp_ctrl_wakeup, lp_data_wakeup}, 0);
    tick();
    reset = 1'b0;
    tick();
    check("t6_rearmed_ctrl", lp_ctrl_req, 1);
    tick();
    check("t6_data_lp_again", data_state, 2);
    lp_ctrl_ack = 1;
    tick();
    ctrl_lp_want = 0; data_lp_want = 0;
    tick();
    check("t6_both_exit", {ctrl_state, data_state}, 4'hf);
    #2 reset = 1'b1;
    #1;
    check("t6_exit_rst_state", {ctrl_state, data_state}, 0);
    check("t6_exit_rst_err", {ctrl_err, data_err}, 0);
    lp_ctrl_ack = 0; lp_data_ack = 0;
    tick();
    reset = 1'b0;
    tick(2);
    check("t6_final_idle", {ctrl_state, data_state, lp_ctrl_req, lp_data_req}, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
